// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared types, limits and parameter check for the instruction fetch port
package ifetch_pkg;
  localparam int MAX_SRAM_LATENCY = 4;
  localparam int MAX_FIFO_DEPTH   = 8;
  localparam int IFETCH_DATA_W    = 32;

  typedef struct packed {
    logic [IFETCH_DATA_W-1:0] data;
    logic                     exc;
  } resp_entry_t;

  function automatic bit ifetch_params_ok(input int latency, input int depth,
                                          input int seg_clr, input int addr_w);
    return (latency >= 1) && (latency <= MAX_SRAM_LATENCY) &&
           (depth >= 1) && (depth <= MAX_FIFO_DEPTH) &&
           (seg_clr >= 0) && (seg_clr < addr_w) && (addr_w >= 2);
  endfunction
endpackage

// File: rtl/ifetch_resp_fifo.sv
// rtl/ifetch_resp_fifo.sv - synchronous response FIFO with occupancy count and clear
module ifetch_resp_fifo
  import ifetch_pkg::*;
#(
  parameter int  DEPTH = 3,
  parameter type T     = resp_entry_t,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  T              push_data,
  input  logic          pop,
  output T              head,
  output logic [CW-1:0] count,
  output logic          empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T              mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          full;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // Upstream credit accounting must keep these from ever happening.
  assert property (@(posedge clk) disable iff (rst || clear) !(push && full && !pop));
  assert property (@(posedge clk) disable iff (rst || clear) !(pop && empty));
endmodule

// File: rtl/inst_fetch_port.sv
// rtl/inst_fetch_port.sv - pipelined valid/ready instruction SRAM port with in-order misalign faults
// Optional IFETCH_PERF_EN adds fetch and stall performance counters.
module inst_fetch_port
  import ifetch_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int SRAM_LATENCY = 1,
  parameter int FIFO_DEPTH   = 3,
  parameter int SEG_CLR_BITS = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] addr,
  input  logic              flush,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] dout,
  output logic              exception,
  output logic              inst_sram_en,
  output logic [3:0]        inst_sram_wen,
  output logic [ADDR_W-1:0] inst_sram_addr,
  output logic [DATA_W-1:0] inst_sram_wdata,
  input  logic [DATA_W-1:0] inst_sram_rdata
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W-1:0] ADDR_MASK = {ADDR_W{1'b1}} >> SEG_CLR_BITS;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              exc;
  } entry_t;

  logic [SRAM_LATENCY-1:0] pipe_valid;
  logic [SRAM_LATENCY-1:0] pipe_exc;
  logic [CW-1:0]           fifo_count;
  logic                    fifo_empty;
  logic                    fifo_pop;
  logic                    fifo_push;
  entry_t                  fifo_head;
  entry_t                  push_entry;
  logic [3:0]              credit_used;
  logic                    misaligned;
  logic                    issue;

  assign misaligned = |addr[1:0];
  // Credit counts every slot in the pipe plus every buffered entry; a same-cycle pop frees nothing yet.
  assign credit_used = 4'($countones(pipe_valid)) + 4'(fifo_count);
  assign req_ready   = !rst && !flush && (credit_used < 4'(FIFO_DEPTH));
  assign issue       = req_valid && req_ready;

  assign inst_sram_en    = issue && !misaligned;
  assign inst_sram_addr  = addr & ADDR_MASK;
  assign inst_sram_wen   = 4'b0000;
  assign inst_sram_wdata = '0;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      pipe_valid <= '0;
    end else begin
      pipe_valid[0] <= issue;
      for (int i = 1; i < SRAM_LATENCY; i++) pipe_valid[i] <= pipe_valid[i-1];
    end
    pipe_exc[0] <= misaligned;
    for (int i = 1; i < SRAM_LATENCY; i++) pipe_exc[i] <= pipe_exc[i-1];
  end

  assign fifo_push       = pipe_valid[SRAM_LATENCY-1];
  assign push_entry.exc  = pipe_exc[SRAM_LATENCY-1];
  assign push_entry.data = pipe_exc[SRAM_LATENCY-1] ? '0 : inst_sram_rdata;
  assign fifo_pop        = resp_valid && resp_ready;

  ifetch_resp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (entry_t)
  ) u_resp_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign resp_valid = !rst && !flush && !fifo_empty;
  assign dout       = fifo_empty ? '0 : fifo_head.data;
  assign exception  = !fifo_empty && fifo_head.exc;

`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (issue)                  perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (req_valid && !req_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

  assert property (@(posedge clk)
    ifetch_params_ok(SRAM_LATENCY, FIFO_DEPTH, SEG_CLR_BITS, ADDR_W));
endmodule

// File: tb/tb_inst_fetch_port.sv
// tb/tb_inst_fetch_port.sv - self-checking bench for inst_fetch_port (L=1/D=3 and L=2/D=2 instances)
module tb_inst_fetch_port;
  typedef struct packed {
    logic [31:0] data;
    logic        exc;
    int          due;
  } exp_t;

  typedef struct {
    bit          rst, rv, fl, rr;
    logic [31:0] addr;
    bit          ra, rb, va, ena;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req_valid, flush, resp_ready;
  logic [31:0] addr;
  logic        rdy [2];
  logic        vld [2];
  logic        exc [2];
  logic        en  [2];
  logic [31:0] dout  [2];
  logic [31:0] saddr [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic [3:0]  wen   [2];
`ifdef IFETCH_PERF_EN
  logic [31:0] pf [2];
  logic [31:0] ps [2];
`endif

  inst_fetch_port #(.SRAM_LATENCY(1), .FIFO_DEPTH(3)) u_dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]), .addr(addr),
    .flush(flush), .resp_valid(vld[0]), .resp_ready(resp_ready), .dout(dout[0]),
    .exception(exc[0]), .inst_sram_en(en[0]), .inst_sram_wen(wen[0]),
    .inst_sram_addr(saddr[0]), .inst_sram_wdata(wdata[0]), .inst_sram_rdata(rdata[0])
`ifdef IFETCH_PERF_EN
    , .perf_fetch_cnt(pf[0]), .perf_stall_cnt(ps[0])
`endif
  );

  inst_fetch_port #(.SRAM_LATENCY(2), .FIFO_DEPTH(2)) u_dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]), .addr(addr),
    .flush(flush), .resp_valid(vld[1]), .resp_ready(resp_ready), .dout(dout[1]),
    .exception(exc[1]), .inst_sram_en(en[1]), .inst_sram_wen(wen[1]),
    .inst_sram_addr(saddr[1]), .inst_sram_wdata(wdata[1]), .inst_sram_rdata(rdata[1])
`ifdef IFETCH_PERF_EN
    , .perf_fetch_cnt(pf[1]), .perf_stall_cnt(ps[1])
`endif
  );

  function automatic logic [31:0] sram_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5C3_1E0F;
  endfunction

  // SRAM stand-in: enabled reads return sram_word(address) after the latency, otherwise noise.
  logic [31:0] sp [2][4];
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      for (int k = 3; k > 0; k--) sp[i][k] <= sp[i][k-1];
      sp[i][0] <= en[i] ? sram_word(saddr[i]) : $urandom;
    end
  end
  assign rdata[0] = sp[0][0];
  assign rdata[1] = sp[1][1];

  int   lat [2] = '{1, 2};
  int   dep [2] = '{3, 2};
  exp_t mq  [2][64];
  int   mh  [2];
  int   mt  [2];
  int   fetch_cnt [2];
  int   stall_cnt [2];
  int   cyc, n_chk, n_fail;
  vec_t tbl [$];

  function automatic bit m_ready(input int i);
    return !rst && !flush && ((mt[i] - mh[i]) < dep[i]);
  endfunction

  function automatic bit m_valid(input int i);
    return !rst && !flush && (mt[i] > mh[i]) && (mq[i][mh[i] % 64].due <= cyc);
  endfunction

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", name, i, cyc, act, exp);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      chk("req_ready", i, 32'(rdy[i]), 32'(m_ready(i)));
      chk("resp_valid", i, 32'(vld[i]), 32'(m_valid(i)));
      chk("sram_en", i, 32'(en[i]), 32'(req_valid && m_ready(i) && (addr[1:0] == 2'b00)));
      chk("sram_addr", i, saddr[i], addr & 32'h1FFF_FFFF);
      chk("sram_wen_wdata", i, 32'(wen[i]) | wdata[i], 32'd0);
      if (m_valid(i)) begin
        chk("dout", i, dout[i], mq[i][mh[i] % 64].data);
        chk("exception", i, 32'(exc[i]), 32'(mq[i][mh[i] % 64].exc));
      end
`ifdef IFETCH_PERF_EN
      chk("perf_fetch", i, pf[i], fetch_cnt[i]);
      chk("perf_stall", i, ps[i], stall_cnt[i]);
`endif
    end
  endtask

  task automatic model_update();
    for (int i = 0; i < 2; i++) begin
      bit r, v;
      r = m_ready(i);
      v = m_valid(i);
      if (rst) begin
        fetch_cnt[i] = 0;
        stall_cnt[i] = 0;
      end else begin
        if (req_valid && r)  fetch_cnt[i]++;
        if (req_valid && !r) stall_cnt[i]++;
      end
      if (rst || flush) begin
        mh[i] = mt[i];
      end else begin
        if (v && resp_ready) mh[i]++;
        if (req_valid && r) begin
          mq[i][mt[i] % 64] = '{data: (addr[1:0] != 2'b00) ? 32'd0 : sram_word(addr & 32'h1FFF_FFFF),
                                exc:  (addr[1:0] != 2'b00),
                                due:  cyc + lat[i] + 1};
          mt[i]++;
        end
      end
    end
  endtask

  task automatic apply(input vec_t v);
    rst = v.rst; req_valid = v.rv; flush = v.fl; resp_ready = v.rr; addr = v.addr;
  endtask

  task automatic run_cycle(input bit use_row, input vec_t v);
    @(negedge clk);
    compare_all();
    if (use_row) begin
      chk("tbl_req_ready", 0, 32'(rdy[0]), 32'(v.ra));
      chk("tbl_req_ready", 1, 32'(rdy[1]), 32'(v.rb));
      chk("tbl_resp_valid", 0, 32'(vld[0]), 32'(v.va));
      chk("tbl_sram_en", 0, 32'(en[0]), 32'(v.ena));
    end
    @(posedge clk);
    model_update();
    cyc++;
    #1;
  endtask

  function automatic void add(input bit r, input bit rv, input bit fl, input bit rr, input logic [31:0] a,
                              input bit ra, input bit rb, input bit va, input bit ena);
    vec_t v;
    v.rst = r; v.rv = rv; v.fl = fl; v.rr = rr; v.addr = a;
    v.ra = ra; v.rb = rb; v.va = va; v.ena = ena;
    tbl.push_back(v);
  endfunction

  initial begin
    vec_t v;
    cyc = 0; n_chk = 0; n_fail = 0;
    for (int i = 0; i < 2; i++) begin
      mh[i] = 0; mt[i] = 0; fetch_cnt[i] = 0; stall_cnt[i] = 0;
    end

    //   rst rv fl rr addr           rdyA rdyB vldA enA
    add(0, 1, 0, 1, 32'h0000_0000, 1, 1, 0, 1);
    add(0, 1, 0, 1, 32'h0000_0004, 1, 1, 0, 1);
    add(0, 1, 0, 1, 32'h0000_0008, 1, 0, 1, 1);
    add(0, 1, 0, 1, 32'h0000_000C, 1, 0, 1, 1);
    add(0, 1, 0, 1, 32'hBFC0_0000, 1, 1, 1, 1);
    add(0, 1, 0, 1, 32'hBFC0_0002, 1, 1, 1, 0);
    add(0, 1, 0, 1, 32'hBFC0_0004, 1, 0, 1, 1);
    add(0, 0, 0, 1, 32'h0,         1, 0, 1, 0);
    add(0, 0, 0, 1, 32'h0,         1, 1, 1, 0);
    add(0, 0, 0, 1, 32'h0,         1, 1, 0, 0);
    add(0, 1, 0, 0, 32'h0000_0100, 1, 1, 0, 1);
    add(0, 1, 0, 0, 32'h0000_0104, 1, 1, 0, 1);
    add(0, 1, 0, 0, 32'h0000_0108, 1, 0, 1, 1);
    add(0, 1, 0, 0, 32'h0000_010C, 0, 0, 1, 0);
    add(0, 1, 0, 0, 32'h0000_0110, 0, 0, 1, 0);
    add(0, 1, 0, 0, 32'h0000_0114, 0, 0, 1, 0);
    add(0, 0, 0, 1, 32'h0,         0, 0, 1, 0);
    add(0, 0, 0, 1, 32'h0,         1, 1, 1, 0);
    add(0, 0, 0, 1, 32'h0,         1, 1, 1, 0);
    add(0, 0, 0, 1, 32'h0,         1, 1, 0, 0);
    add(0, 1, 0, 0, 32'h0000_0200, 1, 1, 0, 1);
    add(0, 1, 0, 0, 32'h0000_0204, 1, 1, 0, 1);
    add(0, 1, 0, 0, 32'h0000_0208, 1, 0, 1, 1);
    add(0, 1, 1, 0, 32'h0000_020C, 0, 0, 0, 0);
    add(0, 0, 0, 1, 32'h0,         1, 1, 0, 0);
    add(0, 0, 0, 1, 32'h0,         1, 1, 0, 0);
    add(0, 0, 0, 1, 32'h0,         1, 1, 0, 0);
    add(0, 1, 0, 1, 32'h0000_0300, 1, 1, 0, 1);
    add(0, 0, 0, 1, 32'h0,         1, 1, 0, 0);
    add(0, 0, 0, 1, 32'h0,         1, 1, 1, 0);
    add(0, 0, 0, 1, 32'h0,         1, 1, 0, 0);
    add(0, 1, 0, 0, 32'h0000_0400, 1, 1, 0, 1);
    add(0, 1, 0, 0, 32'h0000_0404, 1, 1, 0, 1);
    add(1, 1, 0, 0, 32'h0000_0408, 0, 0, 0, 0);
    add(0, 0, 0, 1, 32'h0,         1, 1, 0, 0);

    v = '{default: 0};
    v.rst = 1; v.rv = 1;
    apply(v);
    run_cycle(0, v);
    run_cycle(0, v);
    #2;
    for (int i = 0; i < 2; i++) begin
      chk("reset_req_ready", i, 32'(rdy[i]), 32'd0);
      chk("reset_resp_valid", i, 32'(vld[i]), 32'd0);
      chk("reset_exception", i, 32'(exc[i]), 32'd0);
      chk("reset_dout", i, dout[i], 32'd0);
      chk("reset_sram_en", i, 32'(en[i]), 32'd0);
    end

    foreach (tbl[k]) begin
      apply(tbl[k]);
      run_cycle(1, tbl[k]);
    end

    #2;
    for (int i = 0; i < 2; i++) begin
      chk("post_rst_resp_valid", i, 32'(vld[i]), 32'd0);
      chk("post_rst_dout", i, dout[i], 32'd0);
      chk("post_rst_exception", i, 32'(exc[i]), 32'd0);
`ifdef IFETCH_PERF_EN
      chk("post_rst_perf_fetch", i, pf[i], 32'd0);
      chk("post_rst_perf_stall", i, ps[i], 32'd0);
`endif
    end
    addr = 32'hBFC0_0000;
    #1;
    chk("seg_clear_addr", 0, saddr[0], 32'h1FC0_0000);
    chk("seg_clear_addr", 1, saddr[1], 32'h1FC0_0000);

    for (int n = 0; n < 3000; n++) begin
      v.rst  = ($urandom_range(0, 299) == 0);
      v.fl   = ($urandom_range(0, 39) == 0);
      v.rv   = ($urandom_range(0, 3) != 0);
      v.rr   = ($urandom_range(0, 2) != 0);
      v.addr = $urandom;
      if ($urandom_range(0, 7) != 0) v.addr[1:0] = 2'b00;
      apply(v);
      run_cycle(0, v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
